// File: rtl/mod_updn_counter_if.sv
// Control and status bundle of the modulo up/down counter.
interface mod_updn_counter_if #(
    parameter int unsigned W      = 4,
    parameter int unsigned WRAP_W = 8
);
    logic              en;
    logic              up;
    logic              load;
    logic [W-1:0]      load_val;
    logic              mod_wr;
    logic [W-1:0]      mod_in;
    logic              one_shot;
    logic [W-1:0]      cnt;
    logic              tick;
    logic              done;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              mod_err;

    // Side that issues commands and observes the count.
    modport master (
        output en, up, load, load_val, mod_wr, mod_in, one_shot,
        input  cnt, tick, done, wrap_cnt, mod_err
    );

    // The counter itself.
    modport slave (
        input  en, up, load, load_val, mod_wr, mod_in, one_shot,
        output cnt, tick, done, wrap_cnt, mod_err
    );
endinterface

// File: rtl/mod_updn_counter.sv
// Modulo up/down counter with a deferred modulus update, one-shot halt and a
// saturating wrap counter. All outputs come straight from registers.
module mod_updn_counter #(
    parameter int unsigned W       = 4,
    parameter int unsigned RST_MOD = 10,
    parameter int unsigned WRAP_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    mod_updn_counter_if.slave   bus
);
    localparam int unsigned MOD_MAX = (1 << W) - 1;

    // Reject parameter sets that cannot describe a legal counter.
    if (W < 2) begin : g_bad_w
        $error("mod_updn_counter: W must be at least 2");
    end
    if (RST_MOD < 2 || RST_MOD > MOD_MAX) begin : g_bad_rst_mod
        $error("mod_updn_counter: RST_MOD must lie in 2..2^W-1");
    end

    logic [W-1:0]      cnt_q,   cnt_d;
    logic              tick_q,  tick_d;
    logic              done_q,  done_d;
    logic [WRAP_W-1:0] wrap_q,  wrap_d;
    logic              err_q,   err_d;
    logic [W-1:0]      mod_q,   mod_q_d;
    logic [W-1:0]      mod_p,   mod_p_d;
    logic              p_v,     p_v_d;

    logic [W-1:0]      m_eff;
    logic              wrap;
    logic              apply;

    // Next-state: load beats counting; modulus capture runs alongside both.
    always_comb begin
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        done_d  = done_q;
        wrap_d  = wrap_q;
        err_d   = 1'b0;
        mod_q_d = mod_q;
        mod_p_d = mod_p;
        p_v_d   = p_v;
        wrap    = 1'b0;
        apply   = 1'b0;
        // Modulus in force if this cycle turns out to be a wrap or a load.
        m_eff   = p_v ? mod_p : mod_q;

        if (bus.load) begin
            apply  = 1'b1;
            done_d = 1'b0;
            wrap_d = '0;
            if (bus.load_val < m_eff) begin
                cnt_d = bus.load_val;
            end else begin
                cnt_d = m_eff - W'(1);
                err_d = 1'b1;
            end
        end else if (bus.en && !done_q) begin
            if (bus.up) begin
                if (cnt_q == mod_q - W'(1)) begin
                    cnt_d = '0;
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = m_eff - W'(1);
                    wrap  = 1'b1;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
        end

        if (wrap) begin
            apply  = 1'b1;
            tick_d = 1'b1;
            if (wrap_q != '1) begin
                wrap_d = wrap_q + WRAP_W'(1);
            end
            if (bus.one_shot) begin
                done_d = 1'b1;
            end
        end

        // Pending modulus is consumed first so a same-cycle write stays pending.
        if (apply && p_v) begin
            mod_q_d = mod_p;
            p_v_d   = 1'b0;
        end

        if (bus.mod_wr) begin
            if (bus.mod_in >= W'(2)) begin
                mod_p_d = bus.mod_in;
                p_v_d   = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= '0;
            err_q  <= 1'b0;
            mod_q  <= W'(RST_MOD);
            mod_p  <= '0;
            p_v    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
            mod_q  <= mod_q_d;
            mod_p  <= mod_p_d;
            p_v    <= p_v_d;
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.tick     = tick_q;
    assign bus.done     = done_q;
    assign bus.wrap_cnt = wrap_q;
    assign bus.mod_err  = err_q;
endmodule

// File: tb/tb_mod_updn_counter.sv
// Randomised and directed bench for mod_updn_counter with a scoreboard queue.
module tb_mod_updn_counter;
    localparam int unsigned W       = 4;
    localparam int unsigned RST_MOD = 10;
    localparam int unsigned WRAP_W  = 2;
    localparam int          WRAP_MAX = (1 << WRAP_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mod_updn_counter_if #(.W(W), .WRAP_W(WRAP_W)) bus ();

    mod_updn_counter #(
        .W(W), .RST_MOD(RST_MOD), .WRAP_W(WRAP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int cnt;
        int tick;
        int done;
        int wraps;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: plain integers, pending modulus -1 when none.
    int m_cnt   = 0;
    int m_mod   = RST_MOD;
    int m_pend  = -1;
    int m_done  = 0;
    int m_wraps = 0;
    int m_tick  = 0;
    int m_err   = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Advance the reference by one clock edge with the given inputs.
    task automatic model_step(input bit r, input bit e, input bit u, input bit ld,
                              input int lv, input bit mw, input int mi, input bit os);
        int  m;
        bit  consumed;
        bit  wrapped;
        if (r) begin
            m_cnt = 0; m_mod = RST_MOD; m_pend = -1; m_done = 0;
            m_wraps = 0; m_tick = 0; m_err = 0;
            return;
        end
        m_err    = 0;
        m_tick   = 0;
        consumed = 0;
        wrapped  = 0;
        m = (m_pend >= 0) ? m_pend : m_mod;
        if (ld) begin
            consumed = 1;
            if (lv < m) m_cnt = lv;
            else begin
                m_cnt = m - 1;
                m_err = 1;
            end
            m_done  = 0;
            m_wraps = 0;
        end else if (e && m_done == 0) begin
            if (u) begin
                if (m_cnt + 1 == m_mod) begin m_cnt = 0; wrapped = 1; end
                else m_cnt = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin m_cnt = m - 1; wrapped = 1; end
                else m_cnt = m_cnt - 1;
            end
        end
        if (wrapped) begin
            consumed = 1;
            m_tick   = 1;
            m_wraps  = (m_wraps < WRAP_MAX) ? m_wraps + 1 : WRAP_MAX;
            if (os) m_done = 1;
        end
        if (consumed) begin
            m_mod  = m;
            m_pend = -1;
        end
        if (mw) begin
            if (mi >= 2) m_pend = mi;
            else m_err = 1;
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the edge.
    task automatic drive(input bit r, input bit e, input bit u, input bit ld,
                         input int lv, input bit mw, input int mi, input bit os);
        exp_t x;
        @(negedge clk);
        rst          = r;
        bus.en       = e;
        bus.up       = u;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.mod_wr   = mw;
        bus.mod_in   = W'(mi);
        bus.one_shot = os;
        model_step(r, e, u, ld, lv, mw, mi, os);
        x.cnt = m_cnt; x.tick = m_tick; x.done = m_done; x.wraps = m_wraps; x.err = m_err;
        exp_q.push_back(x);
    endtask

    task automatic idle_count(input bit u, input int n);
        for (int i = 0; i < n; i++) drive(0, 1, u, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every edge yields one output sample to compare with the queue head.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("cnt",      int'(bus.cnt),      x.cnt);
                chk("tick",     int'(bus.tick),     x.tick);
                chk("done",     int'(bus.done),     x.done);
                chk("wrap_cnt", int'(bus.wrap_cnt), x.wraps);
                chk("mod_err",  int'(bus.mod_err),  x.err);
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = '0;
        bus.mod_wr = 1'b0; bus.mod_in = '0; bus.one_shot = 1'b0;

        // Reset, then free-running up count through several wraps.
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        idle_count(1, 25);

        // Down count from reset wraps immediately to 9.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        idle_count(0, 12);

        // Deferred modulus: write 5 at cnt=3, takes effect at the next wrap.
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        idle_count(1, 3);
        drive(0, 1, 1, 0, 0, 1, 5, 0);
        idle_count(1, 18);
        drive(0, 1, 1, 0, 0, 1, 1, 0);
        idle_count(1, 6);

        // Restore modulus 10 via load, then one-shot halt and reload.
        drive(0, 0, 1, 0, 0, 1, 10, 0);
        drive(0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) drive(0, 1, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 1, 7, 0, 0, 1);
        idle_count(1, 3);

        // Clamped load with en high: load wins.
        drive(0, 1, 1, 1, 12, 0, 0, 0);
        idle_count(1, 2);

        // Wrap counter saturation, then reset at cnt=6.
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        idle_count(1, 55);
        n = 0;
        while (m_cnt != 6 && n < 20) begin
            drive(0, 1, 1, 0, 0, 0, 0, 0);
            n++;
        end
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) < 8,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 19) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 14) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 2);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
